// File: rtl/hps_ext_gen.sv
// Command/response engine on a shared 36-bit bus: returns rise counts and a
// status snapshot, and publishes write-command arguments into per-command mailboxes.
module hps_ext_gen #(
   parameter logic [15:0] CMD_BASE   = 16'h00F0,
   parameter int          N_CMD      = 8,
   parameter int          STAT_WORDS = 12,
   parameter int          ARG_WORDS  = 4
) (
   input  logic                              clk_sys,
   input  logic                              reset_n,
   inout  wire  [35:0]                       EXT_BUS,
   input  logic                              hps_rise,
   input  logic [STAT_WORDS*16-1:0]          stat_in,
   output logic [N_CMD-2:0]                  cmd_valid,
   input  logic [N_CMD-2:0]                  cmd_ack,
   output logic [(N_CMD-1)*ARG_WORDS*16-1:0] cmd_args,
   output logic [7:0]                        ovr_cnt,
   output logic                              busy
);
   localparam int          NW      = N_CMD - 1;
   localparam int          AW      = ARG_WORDS * 16;
   localparam logic [16:0] CMD_END = {1'b0, CMD_BASE} + 17'(N_CMD);

   logic [15:0]              io_dout, io_din, cmd, snap_word;
   logic                     dout_en, io_strobe, io_enable, rise_d, pend;
   logic [4:0]               byte_cnt, bi;
   logic [7:0]               rise_cnt;
   logic [3:0]               wr_k;
   logic [AW-1:0]            stag;
   logic [STAT_WORDS*16-1:0] snap;
   logic                     din_ok, is_get, is_wr, publish, ovr_hit;
   logic                     unused_bus;

   assign io_din     = EXT_BUS[31:16];
   assign io_strobe  = EXT_BUS[33];
   assign io_enable  = EXT_BUS[34];
   assign unused_bus = EXT_BUS[35];
   assign EXT_BUS    = {3'bzzz, dout_en, 16'hzzzz, io_dout};

   always_comb begin
      din_ok    = ({1'b0, io_din} >= {1'b0, CMD_BASE}) && ({1'b0, io_din} < CMD_END);
      is_get    = (cmd == CMD_BASE);
      is_wr     = (cmd > CMD_BASE) && ({1'b0, cmd} < CMD_END);
      wr_k      = 4'(cmd - CMD_BASE - 16'd1);
      bi        = byte_cnt - 5'd1;
      snap_word = '0;
      for (int i = 0; i < STAT_WORDS; i++)
         if (bi == 5'(i)) snap_word = snap[16*i +: 16];
      // pend is only ever set by an argument strobe of a write command
      publish   = !io_enable && pend;
      ovr_hit   = 1'b0;
      for (int k = 0; k < NW; k++)
         if (publish && wr_k == 4'(k) && cmd_valid[k] && !cmd_ack[k]) ovr_hit = 1'b1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         io_dout   <= '0;
         dout_en   <= 1'b0;
         byte_cnt  <= '0;
         cmd       <= '0;
         stag      <= '0;
         snap      <= '0;
         pend      <= 1'b0;
         rise_cnt  <= '0;
         rise_d    <= 1'b0;
         cmd_valid <= '0;
         cmd_args  <= '0;
         ovr_cnt   <= '0;
         busy      <= 1'b0;
      end else begin
         busy   <= io_enable;
         rise_d <= hps_rise;
         if (hps_rise != rise_d) rise_cnt <= rise_cnt + 8'd1;

         if (!io_enable) begin
            byte_cnt <= '0;
            cmd      <= '0;
            dout_en  <= 1'b0;
            io_dout  <= '0;
            stag     <= '0;
            pend     <= 1'b0;
         end else if (io_strobe) begin
            if (byte_cnt != 5'd31) byte_cnt <= byte_cnt + 5'd1;
            if (byte_cnt == 5'd0) begin
               cmd     <= io_din;
               dout_en <= din_ok;
               io_dout <= din_ok ? {8'd0, rise_cnt} : 16'd0;
            end else if (is_get) begin
               // byte 1 returns the live word while freezing the whole vector
               if (bi == 5'd0) begin
                  io_dout <= stat_in[15:0];
                  snap    <= stat_in;
               end else begin
                  io_dout <= snap_word;
               end
            end else if (is_wr) begin
               io_dout <= '0;
               for (int i = 0; i < ARG_WORDS; i++)
                  if (bi == 5'(i)) begin
                     stag[16*i +: 16] <= io_din;
                     pend             <= 1'b1;
                  end
            end else begin
               io_dout <= '0;
            end
         end

         for (int k = 0; k < NW; k++) begin
            if (publish && wr_k == 4'(k)) begin
               if (!cmd_valid[k] || cmd_ack[k]) begin
                  cmd_args[k*AW +: AW] <= stag;
                  cmd_valid[k]         <= 1'b1;
               end
            end else if (cmd_ack[k]) begin
               cmd_valid[k] <= 1'b0;
            end
         end
         if (ovr_hit && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end
   end
endmodule
